// File: rtl/bp_l15_pkg.sv
// Shared types and constants for the BlackParrot -> L1.5 store buffer.
package bp_l15_pkg;

  typedef enum logic [1:0] {
    e_size_1b = 2'b00,
    e_size_2b = 2'b01,
    e_size_4b = 2'b10,
    e_size_8b = 2'b11
  } bp_l15_size_e;

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_ld_wait = 2'd1,
    e_st_wait = 2'd2
  } bp_l15_sb_state_e;

  // Load issues in a row, while stores wait, before a store is forced out.
  localparam int unsigned starve_limit_lp = 8;
  localparam int unsigned streak_width_lp = 4;

endpackage

// File: rtl/bp_l15_sb_cam.sv
// Store buffer entry storage with a line-address match vector over valid entries.
module bp_l15_sb_cam #(
  parameter int unsigned els_p            = 4,
  parameter int unsigned paddr_width_p    = 40,
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned block_offset_w_p = 6,
  parameter int unsigned ptr_width_p      = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     w_v_i,
  input  logic [ptr_width_p-1:0]   w_idx_i,
  input  logic [paddr_width_p-1:0] w_addr_i,
  input  logic [dword_width_p-1:0] w_data_i,
  input  logic [1:0]               w_size_i,
  input  logic                     clr_v_i,
  input  logic [ptr_width_p-1:0]   clr_idx_i,
  input  logic [ptr_width_p-1:0]   r_idx_i,
  output logic [paddr_width_p-1:0] r_addr_o,
  output logic [dword_width_p-1:0] r_data_o,
  output logic [1:0]               r_size_o,
  input  logic [paddr_width_p-1:0] cmp_addr_i,
  output logic [els_p-1:0]         match_o
);

  logic [paddr_width_p-1:0] addr_q [els_p];
  logic [dword_width_p-1:0] data_q [els_p];
  logic [1:0]               size_q [els_p];
  logic [els_p-1:0]         valid_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
    end else begin
      if (clr_v_i) valid_q[clr_idx_i] <= 1'b0;
      // Tail and head can only coincide when empty or full, so the write wins.
      if (w_v_i) valid_q[w_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      addr_q[w_idx_i] <= w_addr_i;
      data_q[w_idx_i] <= w_data_i;
      size_q[w_idx_i] <= w_size_i;
    end
  end

  assign r_addr_o = addr_q[r_idx_i];
  assign r_data_o = data_q[r_idx_i];
  assign r_size_o = size_q[r_idx_i];

  always_comb begin
    match_o = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      match_o[i] = valid_q[i] &&
          (addr_q[i][paddr_width_p-1:block_offset_w_p] ==
           cmp_addr_i[paddr_width_p-1:block_offset_w_p]);
    end
  end

endmodule

// File: rtl/bp_l15_store_buffer.sv
// Write-through store queue that shares the transducer request port with D$ load misses.
module bp_l15_store_buffer
  import bp_l15_pkg::*;
#(
  parameter int unsigned els_p            = 4,
  parameter int unsigned paddr_width_p    = 40,
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned block_offset_w_p = 6,
  parameter int unsigned lru_width_p      = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     st_v_i,
  output logic                     st_ready_o,
  input  logic [paddr_width_p-1:0] st_addr_i,
  input  logic [dword_width_p-1:0] st_data_i,
  input  logic [1:0]               st_size_i,
  input  logic                     ld_v_i,
  input  logic [paddr_width_p-1:0] ld_addr_i,
  input  logic [lru_width_p-1:0]   ld_lru_way_i,
  output logic                     ld_yumi_o,
  input  logic                     xdcr_ready_i,
  output logic                     xdcr_v_o,
  output logic                     xdcr_store_o,
  output logic [paddr_width_p-1:0] xdcr_addr_o,
  output logic [lru_width_p-1:0]   xdcr_lru_way_o,
  output logic [dword_width_p-1:0] xdcr_data_o,
  output logic [1:0]               xdcr_size_o,
  input  logic                     xdcr_done_i,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(els_p);
  localparam int unsigned CntW = $clog2(els_p + 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(els_p - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(els_p);
  localparam logic [streak_width_lp-1:0] StarveCnt = streak_width_lp'(starve_limit_lp);

  bp_l15_sb_state_e state_q, state_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [streak_width_lp-1:0] streak_q, streak_d;

  logic                     enq, retire, conflict, starve, take_load;
  logic                     ld_issue, st_issue;
  logic [els_p-1:0]         match;
  logic [paddr_width_p-1:0] head_addr;
  logic [dword_width_p-1:0] head_data;
  logic [1:0]               head_size;

  bp_l15_sb_cam #(
    .els_p           (els_p),
    .paddr_width_p   (paddr_width_p),
    .dword_width_p   (dword_width_p),
    .block_offset_w_p(block_offset_w_p),
    .ptr_width_p     (PtrW)
  ) u_cam (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .w_v_i     (enq),
    .w_idx_i   (tail_q),
    .w_addr_i  (st_addr_i),
    .w_data_i  (st_data_i),
    .w_size_i  (st_size_i),
    .clr_v_i   (retire),
    .clr_idx_i (head_q),
    .r_idx_i   (head_q),
    .r_addr_o  (head_addr),
    .r_data_o  (head_data),
    .r_size_o  (head_size),
    .cmp_addr_i(ld_addr_i),
    .match_o   (match)
  );

  assign st_ready_o = ~reset_i & (count_q != FullCnt);
  assign empty_o    = reset_i | (count_q == '0);
  assign enq        = st_v_i & st_ready_o;
  assign retire     = (state_q == e_st_wait) & xdcr_done_i;
  assign conflict   = ld_v_i & (|match);
  assign starve     = (streak_q >= StarveCnt) & (count_q != '0);
  assign take_load  = ld_v_i & ~conflict & ~starve;

  always_comb begin
    state_d        = state_q;
    xdcr_v_o       = 1'b0;
    xdcr_store_o   = 1'b0;
    xdcr_addr_o    = head_addr;
    xdcr_lru_way_o = '0;
    xdcr_data_o    = head_data;
    xdcr_size_o    = head_size;
    ld_yumi_o      = 1'b0;
    ld_issue       = 1'b0;
    st_issue       = 1'b0;
    unique case (state_q)
      e_idle: begin
        if (take_load) begin
          xdcr_v_o       = ~reset_i;
          xdcr_addr_o    = ld_addr_i;
          xdcr_lru_way_o = ld_lru_way_i;
          if (xdcr_ready_i && !reset_i) begin
            ld_yumi_o = 1'b1;
            ld_issue  = 1'b1;
            state_d   = e_ld_wait;
          end
        end else if (count_q != '0) begin
          xdcr_v_o     = ~reset_i;
          xdcr_store_o = 1'b1;
          if (xdcr_ready_i && !reset_i) begin
            st_issue = 1'b1;
            state_d  = e_st_wait;
          end
        end
      end
      e_ld_wait: if (xdcr_done_i) state_d = e_idle;
      e_st_wait: if (xdcr_done_i) state_d = e_idle;
      default:   state_d = e_idle;
    endcase
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    streak_d = streak_q;
    if (enq)    tail_d = (tail_q == LastIdx) ? '0 : tail_q + 1'b1;
    if (retire) head_d = (head_q == LastIdx) ? '0 : head_q + 1'b1;
    if (enq && !retire)      count_d = count_q + 1'b1;
    else if (!enq && retire) count_d = count_q - 1'b1;
    // Only loads that bypass waiting stores extend the streak.
    if (st_issue) begin
      streak_d = '0;
    end else if (ld_issue) begin
      if (count_q == '0)             streak_d = '0;
      else if (streak_q != StarveCnt) streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_bp_l15_store_buffer.sv
// Directed bench for bp_l15_store_buffer: queueing, arbitration, conflicts, starvation, reset.
module tb_bp_l15_store_buffer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        st_v_i, st_ready_o;
  logic [39:0] st_addr_i;
  logic [63:0] st_data_i;
  logic [1:0]  st_size_i;
  logic        ld_v_i, ld_yumi_o;
  logic [39:0] ld_addr_i;
  logic [2:0]  ld_lru_way_i;
  logic        xdcr_ready_i, xdcr_v_o, xdcr_store_o, xdcr_done_i, empty_o;
  logic [39:0] xdcr_addr_o;
  logic [2:0]  xdcr_lru_way_o;
  logic [63:0] xdcr_data_o;
  logic [1:0]  xdcr_size_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_l15_store_buffer dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .st_v_i        (st_v_i),
    .st_ready_o    (st_ready_o),
    .st_addr_i     (st_addr_i),
    .st_data_i     (st_data_i),
    .st_size_i     (st_size_i),
    .ld_v_i        (ld_v_i),
    .ld_addr_i     (ld_addr_i),
    .ld_lru_way_i  (ld_lru_way_i),
    .ld_yumi_o     (ld_yumi_o),
    .xdcr_ready_i  (xdcr_ready_i),
    .xdcr_v_o      (xdcr_v_o),
    .xdcr_store_o  (xdcr_store_o),
    .xdcr_addr_o   (xdcr_addr_o),
    .xdcr_lru_way_o(xdcr_lru_way_o),
    .xdcr_data_o   (xdcr_data_o),
    .xdcr_size_o   (xdcr_size_o),
    .xdcr_done_i   (xdcr_done_i),
    .empty_o       (empty_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [39:0] addr, input logic [63:0] data);
    st_v_i    = 1'b1;
    st_addr_i = addr;
    st_data_i = data;
    st_size_i = 2'b11;
    tick();
    st_v_i = 1'b0;
  endtask

  // Expects the given store at the head, issues it and completes it.
  task automatic drain_one(input string tag, input logic [39:0] addr);
    #1;
    check_eq({tag, "_v"}, 64'(xdcr_v_o), 64'd1);
    check_eq({tag, "_store"}, 64'(xdcr_store_o), 64'd1);
    check_eq({tag, "_addr"}, 64'(xdcr_addr_o), 64'(addr));
    xdcr_ready_i = 1'b1;
    tick();
    xdcr_ready_i = 1'b0;
    xdcr_done_i  = 1'b1;
    tick();
    xdcr_done_i  = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; st_v_i = 1'b0; st_addr_i = '0; st_data_i = '0; st_size_i = '0;
    ld_v_i = 1'b0; ld_addr_i = '0; ld_lru_way_i = '0; xdcr_ready_i = 1'b0; xdcr_done_i = 1'b0;
    tick(); tick();
    check_eq("rst_xdcr_v", 64'(xdcr_v_o), 64'd0);
    check_eq("rst_ld_yumi", 64'(ld_yumi_o), 64'd0);
    check_eq("rst_st_ready", 64'(st_ready_o), 64'd0);
    check_eq("rst_empty", 64'(empty_o), 64'd1);
    reset_i = 1'b0;
    #1;
    check_eq("post_rst_st_ready", 64'(st_ready_o), 64'd1);

    // 1: single store round trip
    push(40'h1000, 64'h11);
    #1;
    check_eq("t1_v", 64'(xdcr_v_o), 64'd1);
    check_eq("t1_store", 64'(xdcr_store_o), 64'd1);
    check_eq("t1_addr", 64'(xdcr_addr_o), 64'h1000);
    check_eq("t1_data", xdcr_data_o, 64'h11);
    check_eq("t1_size", 64'(xdcr_size_o), 64'd3);
    check_eq("t1_lru", 64'(xdcr_lru_way_o), 64'd0);
    check_eq("t1_not_empty", 64'(empty_o), 64'd0);
    xdcr_ready_i = 1'b1;
    tick();
    xdcr_ready_i = 1'b0;
    #1;
    check_eq("t1_wait_v", 64'(xdcr_v_o), 64'd0);
    check_eq("t1_wait_data", xdcr_data_o, 64'h11);
    xdcr_done_i = 1'b1;
    tick();
    xdcr_done_i = 1'b0;
    check_eq("t1_empty", 64'(empty_o), 64'd1);

    // 2: fill, retire one, enqueue+retire in one cycle, wraparound drain
    for (int i = 0; i < 4; i++) push(40'h5000 + 40'(i * 64), 64'(i + 1));
    #1;
    check_eq("t2_full", 64'(st_ready_o), 64'd0);
    drain_one("t2_d0", 40'h5000);
    check_eq("t2_ready_after_done", 64'(st_ready_o), 64'd1);
    xdcr_ready_i = 1'b1;
    tick();
    xdcr_ready_i = 1'b0;
    st_v_i = 1'b1; st_addr_i = 40'h5100; st_data_i = 64'h5;
    xdcr_done_i = 1'b1;
    tick();
    st_v_i = 1'b0; xdcr_done_i = 1'b0;
    check_eq("t2_enq_retire_ready", 64'(st_ready_o), 64'd1);
    push(40'h5140, 64'h6);
    check_eq("t2_full_again", 64'(st_ready_o), 64'd0);
    drain_one("t2_d2", 40'h5080);
    drain_one("t2_d3", 40'h50c0);
    drain_one("t2_d4", 40'h5100);
    drain_one("t2_d5", 40'h5140);
    check_eq("t2_empty", 64'(empty_o), 64'd1);

    // 3: conflicting load waits for the store to drain
    push(40'h2008, 64'h22);
    ld_v_i = 1'b1; ld_addr_i = 40'h2000; ld_lru_way_i = 3'd5;
    #1;
    check_eq("t3_yumi_blocked", 64'(ld_yumi_o), 64'd0);
    check_eq("t3_store_first", 64'(xdcr_store_o), 64'd1);
    xdcr_ready_i = 1'b1;
    tick();
    check_eq("t3_yumi_wait", 64'(ld_yumi_o), 64'd0);
    xdcr_done_i = 1'b1;
    tick();
    xdcr_done_i = 1'b0;
    check_eq("t3_yumi", 64'(ld_yumi_o), 64'd1);
    check_eq("t3_ld_store", 64'(xdcr_store_o), 64'd0);
    check_eq("t3_ld_addr", 64'(xdcr_addr_o), 64'h2000);
    check_eq("t3_ld_lru", 64'(xdcr_lru_way_o), 64'd5);
    tick();
    ld_v_i = 1'b0; xdcr_ready_i = 1'b0; xdcr_done_i = 1'b1;
    tick();
    xdcr_done_i = 1'b0;

    // 4: non-conflicting load goes ahead of a queued store
    push(40'h3000, 64'h33);
    ld_v_i = 1'b1; ld_addr_i = 40'h4000; ld_lru_way_i = 3'd2; xdcr_ready_i = 1'b1;
    #1;
    check_eq("t4_yumi", 64'(ld_yumi_o), 64'd1);
    check_eq("t4_ld_addr", 64'(xdcr_addr_o), 64'h4000);
    tick();
    ld_v_i = 1'b0; xdcr_ready_i = 1'b0;
    check_eq("t4_ld_wait_v", 64'(xdcr_v_o), 64'd0);
    xdcr_done_i = 1'b1;
    tick();
    xdcr_done_i = 1'b0;
    drain_one("t4_st", 40'h3000);
    check_eq("t4_empty", 64'(empty_o), 64'd1);

    // 5: starvation guard after 8 bypassing loads
    push(40'h7000, 64'h77);
    ld_v_i = 1'b1; xdcr_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ld_addr_i = 40'h8000 + 40'(k * 64);
      #1;
      check_eq($sformatf("t5_load%0d", k), 64'(ld_yumi_o), 64'd1);
      tick();
      xdcr_done_i = 1'b1;
      tick();
      xdcr_done_i = 1'b0;
    end
    ld_addr_i = 40'h8200;
    #1;
    check_eq("t5_forced_yumi", 64'(ld_yumi_o), 64'd0);
    check_eq("t5_forced_store", 64'(xdcr_store_o), 64'd1);
    check_eq("t5_forced_addr", 64'(xdcr_addr_o), 64'h7000);
    tick();
    xdcr_done_i = 1'b1;
    tick();
    xdcr_done_i = 1'b0;
    check_eq("t5_load_resumes", 64'(ld_yumi_o), 64'd1);
    tick();
    ld_v_i = 1'b0; xdcr_ready_i = 1'b0; xdcr_done_i = 1'b1;
    tick();
    xdcr_done_i = 1'b0;

    // 6: reset while a store is outstanding
    push(40'h9000, 64'h90);
    push(40'h9040, 64'h91);
    push(40'h9080, 64'h92);
    xdcr_ready_i = 1'b1;
    tick();
    xdcr_ready_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    check_eq("t6_v", 64'(xdcr_v_o), 64'd0);
    check_eq("t6_empty", 64'(empty_o), 64'd1);
    push(40'ha000, 64'haa);
    #1;
    check_eq("t6_data", xdcr_data_o, 64'haa);
    drain_one("t6_first", 40'ha000);
    check_eq("t6_final_empty", 64'(empty_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
